// File: rtl/pp_game_if.sv
// Event and status bundle between the ping-pong game sequencer and its neighbours.
interface pp_game_if #(parameter int SCORE_W = 4);
  logic               start;
  logic               frame_tick;
  logic               ball_out_l;
  logic               ball_out_r;
  logic               hit_l;
  logic               hit_r;
  logic               ball_run;
  logic               serve_load;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic [7:0]         rally_len;
  logic               flag;
  logic               winner;
  logic [2:0]         state;

  modport master (
    output start, frame_tick, ball_out_l, ball_out_r, hit_l, hit_r,
    input  ball_run, serve_load, serve_dir, score_l, score_r, rally_len,
           flag, winner, state
  );

  modport slave (
    input  start, frame_tick, ball_out_l, ball_out_r, hit_l, hit_r,
    output ball_run, serve_load, serve_dir, score_l, score_r, rally_len,
           flag, winner, state
  );
endinterface

// File: rtl/pp_game_ctrl.sv
// Game-flow sequencer: serve / rally / point pause / game over, plus score keeping.
// Every output is a register loaded from the next-state logic.
module pp_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int SCORE_W      = 4,
  parameter int CNT_W        = 8
) (
  input  logic      clk,
  input  logic      rst,
  pp_game_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE_S   = SCORE_W'(1);
  localparam logic [CNT_W-1:0]   SERVE_N = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_N = CNT_W'(POINT_FRAMES);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [SCORE_W-1:0] score_l, score_l_n, score_r, score_r_n;
  logic [7:0]         rally_len, rally_len_n;
  logic               serve_dir, serve_dir_n;
  logic               winner, winner_n;
  logic               ball_run, serve_load, flag;
  logic               start_d, start_rise;

  assign start_rise = bus.start & ~start_d;
  assign cnt_inc    = cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      score_l    <= '0;
      score_r    <= '0;
      rally_len  <= '0;
      serve_dir  <= 1'b0;
      winner     <= 1'b0;
      ball_run   <= 1'b0;
      serve_load <= 1'b0;
      flag       <= 1'b0;
      start_d    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      score_l    <= score_l_n;
      score_r    <= score_r_n;
      rally_len  <= rally_len_n;
      serve_dir  <= serve_dir_n;
      winner     <= winner_n;
      ball_run   <= (state_n == RALLY);
      serve_load <= (state_n == SERVE) && (state != SERVE);
      flag       <= (state_n == OVER);
      start_d    <= bus.start;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    score_l_n   = score_l;
    score_r_n   = score_r;
    rally_len_n = rally_len;
    serve_dir_n = serve_dir;
    winner_n    = winner;

    case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          state_n     = SERVE;
          score_l_n   = '0;
          score_r_n   = '0;
          rally_len_n = '0;
          serve_dir_n = 1'b0;
          winner_n    = 1'b0;
        end
      end
      SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_inc == SERVE_N) state_n = RALLY;
          else                    cnt_n   = cnt_inc;
        end
      end
      RALLY: begin
        if ((bus.hit_l || bus.hit_r) && rally_len != 8'hff)
          rally_len_n = rally_len + 8'd1;
        // a double exit is a let: no point awarded, server side kept
        if (bus.ball_out_l && bus.ball_out_r) begin
          state_n = POINT;
        end else if (bus.ball_out_l) begin
          score_r_n   = score_r + ONE_S;
          serve_dir_n = 1'b1;
          state_n     = POINT;
        end else if (bus.ball_out_r) begin
          score_l_n   = score_l + ONE_S;
          serve_dir_n = 1'b0;
          state_n     = POINT;
        end
      end
      POINT: begin
        if (bus.frame_tick) begin
          if (cnt_inc == POINT_N) begin
            if (score_l == WIN_S || score_r == WIN_S) begin
              state_n  = OVER;
              winner_n = (score_r == WIN_S);
            end else begin
              state_n     = SERVE;
              rally_len_n = '0;
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n != state) cnt_n = '0;
  end

  assign bus.state      = state;
  assign bus.score_l    = score_l;
  assign bus.score_r    = score_r;
  assign bus.rally_len  = rally_len;
  assign bus.serve_dir  = serve_dir;
  assign bus.winner     = winner;
  assign bus.ball_run   = ball_run;
  assign bus.serve_load = serve_load;
  assign bus.flag       = flag;
endmodule

// File: tb/tb_pp_game_ctrl.sv
// Scenario bench for pp_game_ctrl: expected output snapshots are queued with the
// stimulus and popped for comparison once the DUT has responded.
module tb_pp_game_ctrl;
  typedef struct packed {
    logic [2:0] st;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [7:0] rl;
    logic       sd;
    logic       br;
    logic       sload;
    logic       fl;
    logic       wn;
  } snap_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  snap_t obs, e;
  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  pp_game_if #(.SCORE_W(4)) bus();

  pp_game_ctrl #(
    .WIN_SCORE(3), .SERVE_FRAMES(2), .POINT_FRAMES(3), .SCORE_W(4), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign obs = {bus.state, bus.score_l, bus.score_r, bus.rally_len, bus.serve_dir,
                bus.ball_run, bus.serve_load, bus.flag, bus.winner};

  // ball_run is high exactly in RALLY
  function automatic snap_t mk(input logic [2:0] st, input logic [3:0] sl, input logic [3:0] sr,
                               input logic [7:0] rl, input logic sd, input logic sload,
                               input logic fl, input logic wn);
    mk = {st, sl, sr, rl, sd, (st == 3'd2), sload, fl, wn};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_frame();
    repeat (9) cyc();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.frame_tick = 0; bus.ball_out_l = 0; bus.ball_out_r = 0;
    bus.hit_l = 0; bus.hit_r = 0;
    rst = 1'b1;
    exp_q.push_back(mk(3'd0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) cyc();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
    rst = 1'b0;
    exp_q.push_back(mk(3'd0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) cyc();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL idle_after_reset got=%h exp=%h", obs, e); end
  endtask

  task automatic test_start_serve();
    bus.start = 1'b1;
    exp_q.push_back(mk(3'd1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc();
    bus.start = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL start_serve_load got=%h exp=%h", obs, e); end
    exp_q.push_back(mk(3'd1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL serve_load_drop got=%h exp=%h", obs, e); end
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(mk(i == 2 ? 3'd2 : 3'd1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      tick_frame();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL serve_tick%0d got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_rally_point();
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(mk(3'd2, 4'd0, 4'd0, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0));
      bus.hit_r = 1'b1;
      cyc();
      bus.hit_r = 1'b0;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL hit_r%0d got=%h exp=%h", i, obs, e); end
      cyc();
    end
    exp_q.push_back(mk(3'd3, 4'd0, 4'd1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    bus.ball_out_l = 1'b1;
    cyc();
    bus.ball_out_l = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL out_l_point got=%h exp=%h", obs, e); end
    for (int i = 1; i <= 3; i++) begin
      if (i < 3) exp_q.push_back(mk(3'd3, 4'd0, 4'd1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0));
      else       exp_q.push_back(mk(3'd1, 4'd0, 4'd1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0));
      tick_frame();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL point_tick%0d got=%h exp=%h", i, obs, e); end
    end
    exp_q.push_back(mk(3'd1, 4'd0, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reserve_load_drop got=%h exp=%h", obs, e); end
    exp_q.push_back(mk(3'd2, 4'd0, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    repeat (2) tick_frame();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rally2_entry got=%h exp=%h", obs, e); end
  endtask

  task automatic test_double_out();
    // both outs plus both hits: no score, one rally increment
    exp_q.push_back(mk(3'd3, 4'd0, 4'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    bus.ball_out_l = 1; bus.ball_out_r = 1; bus.hit_l = 1; bus.hit_r = 1;
    cyc();
    bus.ball_out_l = 0; bus.ball_out_r = 0; bus.hit_l = 0; bus.hit_r = 0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL double_out got=%h exp=%h", obs, e); end
    exp_q.push_back(mk(3'd1, 4'd0, 4'd1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    repeat (3) tick_frame();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL double_out_reserve got=%h exp=%h", obs, e); end
    repeat (2) tick_frame();
  endtask

  task automatic test_left_wins();
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(mk(3'd3, 4'(k), 4'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      bus.ball_out_r = 1'b1;
      cyc();
      bus.ball_out_r = 1'b0;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL win_point%0d got=%h exp=%h", k, obs, e); end
      if (k < 3) exp_q.push_back(mk(3'd1, 4'(k), 4'd1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      else       exp_q.push_back(mk(3'd4, 4'd3, 4'd1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      repeat (3) tick_frame();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL win_pause%0d got=%h exp=%h", k, obs, e); end
      if (k < 3) repeat (2) tick_frame();
    end
    exp_q.push_back(mk(3'd4, 4'd3, 4'd1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    bus.ball_out_l = 1; bus.hit_r = 1;
    cyc();
    bus.ball_out_l = 0; bus.hit_r = 0;
    bus.ball_out_r = 1; bus.hit_l = 1;
    cyc();
    bus.ball_out_r = 0; bus.hit_l = 0;
    tick_frame();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL over_hold got=%h exp=%h", obs, e); end
  endtask

  task automatic test_restart_hold();
    bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(mk(3'd1, 4'd0, 4'd0, 8'd0, 1'b0, i == 0, 1'b0, 1'b0));
      cyc();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL restart_cyc%0d got=%h exp=%h", i, obs, e); end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_mid_rally();
    repeat (2) tick_frame();
    for (int k = 1; k <= 2; k++) begin
      bus.ball_out_r = 1'b1;
      cyc();
      bus.ball_out_r = 1'b0;
      repeat (5) tick_frame();
    end
    exp_q.push_back(mk(3'd2, 4'd2, 4'd0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.hit_l = 1'b1;
    repeat (260) cyc();
    bus.hit_l = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rally_saturate got=%h exp=%h", obs, e); end
    exp_q.push_back(mk(3'd0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    bus.start = 1'b1;
    #2;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
    cyc();
    rst = 1'b0;
    exp_q.push_back(mk(3'd1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL start_at_release got=%h exp=%h", obs, e); end
    exp_q.push_back(mk(3'd1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL no_second_start got=%h exp=%h", obs, e); end
    bus.start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_serve();
    test_rally_point();
    test_double_out();
    test_left_wins();
    test_restart_hold();
    test_reset_mid_rally();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pp_game_ctrl.md
Name: pp_game_ctrl

Overview:
Game-flow sequencer for the ping-pong display pipeline. It sequences the ball engine through serve, rally and point phases, and keeps both players' scores. It also raises the game-over flag consumed by the top level. It sits between the start/paddle event sources and the ball/VGA render datapath, and is paced by the per-frame tick.

Parameters:
WIN_SCORE, 7, score that ends the game; must be ≤ 2^SCORE_W-1
SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released; ≥1
POINT_FRAMES, 90, frame ticks of pause after a point; ≥1
SCORE_W, 4, score counter width
CNT_W, 8, frame-counter width; must hold max(SERVE_FRAMES, POINT_FRAMES)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous, active-high reset
start  in  1  level start request, synchronous to clk; rising edge is used
frame_tick  in  1  one-cycle pulse per video frame (start of vsync)
ball_out_l  in  1  pulse: ball crossed left boundary
ball_out_r  in  1  pulse: ball crossed right boundary
hit_l  in  1  pulse: left paddle hit ball
hit_r  in  1  pulse: right paddle hit ball
ball_run  out  1  enables ball motion
serve_load  out  1  one-cycle pulse: reload ball to centre
serve_dir  out  1  0 = serve toward right, 1 = toward left
score_l  out  SCORE_W  left score
score_r  out  SCORE_W  right score
rally_len  out  8  paddle hits in current rally, saturating at 255
flag  out  1  game over
winner  out  1  0 = left won, 1 = right won; valid while flag=1
state  out  3  IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4

Behaviour:
Output registration
- All outputs are registered.
- Each response appears on the clk edge after the triggering input cycle.

Reset
- Reset values: state=IDLE, all scores 0, rally_len 0, ball_run 0, serve_load 0, serve_dir 0, flag 0, winner 0, frame counter 0, start_d 0.
- Reset asserted in any state aborts immediately to these values.

Start detection
- start_rise = start & ~start_d.
- If start is high when reset releases, this counts as a rise on the first cycle.

IDLE
- On start_rise: go to SERVE, clear scores and rally_len, serve_dir=0, pulse serve_load.

SERVE
- ball_run=0.
- Frame counter increments on frame_tick.
- On the tick that brings the count to SERVE_FRAMES: go to RALLY, ball_run=1, counter cleared.
- ball_out_*, hit_* and start are ignored.

RALLY
- ball_run=1.
- hit_l or hit_r increments rally_len by 1, saturating at 255. Both in the same cycle also add 1.
- ball_out_l: score_r+1, serve_dir=1, go to POINT.
- ball_out_r: score_l+1, serve_dir=0, go to POINT.
- Both ball_out_* in the same cycle: no score change, serve_dir unchanged, go to POINT.
- A hit in the same cycle as ball_out is still counted.
- frame_tick and start are ignored.

POINT
- ball_run=0.
- Counts frame_tick up to POINT_FRAMES. On the final tick:
  - if score_l==WIN_SCORE or score_r==WIN_SCORE: go to OVER, flag=1, winner=(score_r==WIN_SCORE);
  - otherwise: go to SERVE, pulse serve_load, clear rally_len.

OVER
- flag=1. Scores, winner and rally_len are held.
- On start_rise: behave exactly as the IDLE start (scores cleared, flag=0, serve_load pulse, go to SERVE).

Frame counter and serve_load
- Frame counter clears on every state transition.
- frame_tick in the same cycle as a transition is not counted in the new state.
- serve_load is high exactly during the first cycle that state==SERVE and is never asserted otherwise.

Invariant
- Scores never exceed WIN_SCORE: OVER is entered before any further increment is possible.

Test Plan:
Bench parameters: SERVE_FRAMES=2, POINT_FRAMES=3, WIN_SCORE=3, with frame_tick every 10 cycles.

1. Reset, then pulse start -> state 0→1 next edge, serve_load high 1 cycle, serve_dir=0. After 2 frame_ticks: state=2, ball_run=1.
2. In RALLY, hit_r×3 then ball_out_l -> rally_len=3, score_r=1, serve_dir=1, state=3, ball_run=0. After 3 ticks: state=1, serve_load pulse, rally_len=0.
3. In RALLY, ball_out_l and ball_out_r in the same cycle -> scores unchanged, state=3, serve_dir unchanged.
4. Left wins 3 points (ball_out_r ×3 across rallies) -> after the third POINT pause: state=4, flag=1, winner=0, score_l=3. Further ball_out/hit pulses cause no change.
5. In OVER, hold start high for 20 cycles -> exactly one restart: scores 0, flag 0, single serve_load pulse, state=1.
6. Assert rst mid-RALLY with score_l=2 -> all outputs return to reset values asynchronously (before the next clk edge). Start held high through reset release -> SERVE entered on the first cycle after release.
